// File: rtl/seg7_scroll_display.sv
// Multiplexed seven-segment driver with a static hex view and an optional scrolling
// message buffer; the scroll feature (buffer, FSM, timer) is built only when SEG7_SCROLL_EN is defined.
module seg7_scroll_display #(
   parameter int NUM_DIGITS   = 4,
   parameter int DEPTH        = 16,
   parameter int REFRESH_BITS = 18,
   parameter int SCROLL_TICKS = 50000000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        mode,
   input  logic                        pause,
   input  logic [4*NUM_DIGITS-1:0]     data_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic                        wr_en,
   input  logic [$clog2(DEPTH)-1:0]    wr_addr,
   input  logic [4:0]                  wr_data,
   input  logic [$clog2(DEPTH):0]      msg_len,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [$clog2(DEPTH)-1:0]    scroll_pos
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic [REFRESH_BITS-1:0] rcnt_q, rcnt_d;
   logic [DW-1:0]           digit_q, digit_d;
   logic [4*NUM_DIGITS-1:0] din_q;
   logic [6:0]              seg_q, seg_d, static_seg;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   always_comb begin
      rcnt_d  = rcnt_q + 1'b1;
      digit_d = digit_q;
      if (rcnt_q == '1)
         digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
      an_d       = ~(NUM_DIGITS'(1) << digit_q);
      dp_d       = ~dp_in[digit_q];
      static_seg = hex7(din_q[4*digit_q +: 4]);
   end

`ifdef SEG7_SCROLL_EN
   typedef enum logic [1:0] {ST_STATIC, ST_RUN, ST_PAUSED} state_t;
   localparam int TW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [AW-1:0] pos_q, pos_d;
   logic [4:0]    buf_q [DEPTH];
   logic [AW:0]   k_raw, k_adj;
   logic [4:0]    entry;
   logic [6:0]    scroll_seg;

   always_comb begin
      case (state_q)
         ST_STATIC: state_d = ST_RUN;
         ST_RUN:    state_d = pause ? ST_PAUSED : ST_RUN;
         ST_PAUSED: state_d = pause ? ST_PAUSED : ST_RUN;
         default:   state_d = ST_STATIC;
      endcase
      if (!mode)
         state_d = ST_STATIC;

      tmr_d = tmr_q;
      pos_d = pos_q;
      if (state_d == ST_STATIC) begin
         tmr_d = '0;
         pos_d = '0;
      end else if (state_q == ST_RUN) begin
         if (tmr_q == TW'(SCROLL_TICKS - 1)) begin
            tmr_d = '0;
            pos_d = (({1'b0, pos_q} + 1'b1) >= msg_len) ? '0 : pos_q + 1'b1;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
      // A shrunk message can leave the position past its end; snap back to the start.
      if ({1'b0, pos_q} >= msg_len)
         pos_d = '0;

      k_raw = {1'b0, pos_q} + (AW+1)'(NUM_DIGITS - 1 - int'(digit_q));
      k_adj = (k_raw >= msg_len) ? k_raw - msg_len : k_raw;
      entry = buf_q[k_adj[AW-1:0]];
      scroll_seg = ((k_adj >= msg_len) || entry[4]) ? 7'h7F : hex7(entry[3:0]);
      seg_d = (state_q == ST_STATIC) ? static_seg : scroll_seg;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_STATIC;
         tmr_q   <= '0;
         pos_q   <= '0;
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= 5'h10;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pos_q   <= pos_d;
         if (wr_en)
            buf_q[wr_addr] <= wr_data;
      end
   end

   assign scroll_pos = pos_q;
`else
   logic unused_scroll_inputs;
   assign unused_scroll_inputs = ^{mode, pause, wr_en, wr_addr, wr_data, msg_len};

   always_comb begin
      seg_d = static_seg;
   end

   assign scroll_pos = '0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         rcnt_q  <= '0;
         digit_q <= '0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= '1;
      end else begin
         rcnt_q  <= rcnt_d;
         digit_q <= digit_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   // Static value is sampled every cycle regardless of reset; it is pure data.
   always_ff @(posedge clock) begin
      din_q <= data_in;
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;
endmodule

// File: tb/tb_seg7_scroll_display.sv
// Randomized bench for seg7_scroll_display against a cycle-level behavioural model of the
// display rules; scroll sequences are exercised only when SEG7_SCROLL_EN is defined.
module tb_seg7_scroll_display;
   localparam int N     = 4;
   localparam int DEPTH = 16;
   localparam int RB    = 4;
   localparam int STK   = 10;
   localparam int AW    = 4;

   localparam logic [6:0] HEX_TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic          clock = 1'b0;
   logic          reset, mode, pause, wr_en;
   logic [4*N-1:0] data_in;
   logic [N-1:0]  dp_in;
   logic [AW-1:0] wr_addr;
   logic [4:0]    wr_data;
   logic [AW:0]   msg_len;
   logic [6:0]    seg;
   logic          dp;
   logic [N-1:0]  an;
   logic [AW-1:0] scroll_pos;

   always #5 clock = ~clock;

   seg7_scroll_display #(
      .NUM_DIGITS(N), .DEPTH(DEPTH), .REFRESH_BITS(RB), .SCROLL_TICKS(STK)
   ) dut (
      .clock(clock), .reset(reset), .mode(mode), .pause(pause),
      .data_in(data_in), .dp_in(dp_in), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .msg_len(msg_len), .seg(seg), .dp(dp), .an(an),
      .scroll_pos(scroll_pos)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model state
   int           m_cyc;
   logic [4*N-1:0] m_din;
   logic [6:0]   exp_seg;
   logic         exp_dp;
   logic [N-1:0] exp_an;
   int           m_pos;
`ifdef SEG7_SCROLL_EN
   int           m_state;   // 0 static, 1 run, 2 paused
   int           m_tmr;
   logic [4:0]   m_buf [DEPTH];
`endif

   task automatic model_edge();
      int d, k, len, nst, old_pos;
      if (!reset) begin
         exp_an  = '1;
         exp_seg = 7'h7F;
         exp_dp  = 1'b1;
         m_cyc   = 0;
         m_pos   = 0;
`ifdef SEG7_SCROLL_EN
         m_state = 0;
         m_tmr   = 0;
         for (int i = 0; i < DEPTH; i++) m_buf[i] = 5'h10;
`endif
      end else begin
         d = (m_cyc / (1 << RB)) % N;
         exp_an    = '1;
         exp_an[d] = 1'b0;
         exp_dp    = ~dp_in[d];
         exp_seg   = HEX_TBL[m_din[4*d +: 4]];
         m_cyc++;
`ifdef SEG7_SCROLL_EN
         len = int'(msg_len);
         if (m_state != 0) begin
            k = m_pos + (N - 1 - d);
            if (k >= len) k -= len;
            if (k >= len || m_buf[k][4]) exp_seg = 7'h7F;
            else exp_seg = HEX_TBL[m_buf[k][3:0]];
         end
         if (!mode) nst = 0;
         else if (m_state == 0) nst = 1;
         else nst = pause ? 2 : 1;
         old_pos = m_pos;
         if (nst == 0) begin
            m_tmr = 0;
            m_pos = 0;
         end else begin
            if (m_state == 1) begin
               if (m_tmr == STK - 1) begin
                  m_tmr = 0;
                  if (len > 0) m_pos = (m_pos + 1) % len;
               end else begin
                  m_tmr++;
               end
            end
            if (old_pos >= len) m_pos = 0;
         end
         m_state = nst;
         if (wr_en) m_buf[wr_addr] = wr_data;
`endif
      end
      m_din = data_in;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_edge();
         @(negedge clock);
         check("an", 32'(an), 32'(exp_an));
         check("seg", 32'(seg), 32'(exp_seg));
         check("dp", 32'(dp), 32'(exp_dp));
         check("scroll_pos", 32'(scroll_pos), 32'(m_pos));
      end
   endtask

   initial begin
      reset = 1'b0; mode = 1'b0; pause = 1'b0;
      data_in = 16'($urandom); dp_in = '0;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 5'h05; msg_len = '0;
      m_din = '0; m_pos = 0;
      cyc(3);

      // Static refresh sweep over 12AF
      reset = 1'b1; wr_en = 1'b0;
      data_in = 16'h12AF;
      cyc(80);

`ifdef SEG7_SCROLL_EN
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = 5'(i + 1);
         cyc(1);
      end
      wr_en = 1'b0; msg_len = 5'd6; mode = 1'b1;
      cyc(95);
      pause = 1'b1; cyc(50);
      pause = 1'b0; cyc(5);
      mode = 1'b0; cyc(3);
      mode = 1'b1; cyc(25);
      msg_len = 5'd2; cyc(20);
      msg_len = 5'd6; cyc(60);
      msg_len = 5'd4; cyc(5);
      msg_len = 5'd0; cyc(15);
      msg_len = 5'd6; cyc(20);
      reset = 1'b0; cyc(2);
      reset = 1'b1; cyc(20);
`endif

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) data_in = 16'($urandom);
         if ($urandom_range(0, 7) == 0) dp_in = N'($urandom);
         if ($urandom_range(0, 63) == 0) mode = ~mode;
         if ($urandom_range(0, 31) == 0) pause = ~pause;
         if ($urandom_range(0, 99) == 0) msg_len = 5'($urandom_range(0, DEPTH));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = AW'($urandom);
         wr_data = 5'($urandom);
         reset   = ($urandom_range(0, 299) != 0);
         cyc(1);
      end
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
